ksa_shuffle_fsm: RTL and testbench
==================================

KSA_SHUFFLE_FSM -- requirements
Module: ksa_shuffle_fsm

Interface
REQ-001 The block SHALL have parameter KEY_BYTES, default 3: secret key length in bytes.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: level request from the sequencer, held high for the whole operation.
REQ-005 The block SHALL have port secret_key, input, 8*KEY_BYTES bits: key; byte 0 = secret_key[8*KEY_BYTES-1 -: 8] (MSB first).
REQ-006 The block SHALL have port s_q, input, 8 bits: S-memory read data.
REQ-007 The block SHALL have port s_address, output, 8 bits: S-memory address.
REQ-008 The block SHALL have port s_data, output, 8 bits: S-memory write data.
REQ-009 The block SHALL have port s_wren, output, 1 bit: S-memory write enable.
REQ-010 The block SHALL have port done, output, 1 bit: shuffle complete, held while start stays high.

Function
REQ-011 The block SHALL run the RC4 key-schedule swap loop: for i = 0..255: j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j].
REQ-012 The block SHALL initialise i and j to 0 on each start.
REQ-013 All index arithmetic SHALL be 8-bit, wrapping modulo 256 with no carry retained.
REQ-014 The block SHALL assume memory read latency of 2 cycles: s_q is valid 2 edges after s_address is first presented, with the address held.
REQ-015 States SHALL be IDLE, RD_I, WT_I, LT_I, RD_J, WT_J, LT_J, WR_I, WR_J, DONE.
REQ-016 IDLE SHALL go to RD_I on the first edge where start=1, clearing i and j.
REQ-017 RD_I->WT_I->LT_I SHALL drive s_address=i; LT_I SHALL capture s_i=s_q and update j.
REQ-018 RD_J->WT_J->LT_J SHALL drive s_address=j (the new j); LT_J SHALL capture s_j=s_q.
REQ-019 WR_I SHALL drive s_address=i, s_data=s_j, s_wren=1.
REQ-020 WR_J SHALL drive s_address=j, s_data=s_i, s_wren=1.
REQ-021 From WR_J the block SHALL go to DONE if i==255, else increment i and go to RD_I.
REQ-022 An iteration SHALL take 8 cycles; DONE SHALL be entered exactly 2048 edges after leaving IDLE.
REQ-023 done=1 only in DONE; DONE SHALL return to IDLE on the first edge where start=0.
REQ-024 If start=0 in any non-IDLE state, the block SHALL abort to IDLE on the next edge with no further writes.
REQ-025 When i==j, both writes SHALL target the same address; the net memory value SHALL be unchanged.
REQ-026 s_wren SHALL be 0 in every state except WR_I and WR_J.
REQ-027 In IDLE and DONE, s_address SHALL be 0 and s_data SHALL be 0.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, i=0, j=0, s_i=0, s_j=0, done=0, s_wren=0, s_address=0, s_data=0.
REQ-029 Reset assertion mid-operation SHALL abandon the loop; a later start SHALL restart from i=0.
REQ-030 Reset release SHALL take effect on a clock edge; start is sampled no earlier than the first edge after release.

Configuration
REQ-031 With KSA_SHUFFLE_SKIP_EQUAL_EN defined, LT_I SHALL, when new j==i, skip RD_J..WR_J: go to DONE if i==255, else i+1 and RD_I (a 3-cycle iteration).
REQ-032 Without KSA_SHUFFLE_SKIP_EQUAL_EN, every iteration SHALL take 8 cycles and SHALL include both writes regardless of i==j.

Verification
REQ-033 Identity S, key 0x000000, start held: s[0],s[1] unchanged; s[2]=3, s[3]=2 after iteration 2; done rises 2048 edges after leaving IDLE (macro off).
REQ-034 Full-run golden check: key 0x000102 -> final S matches the software KSA model for all 256 bytes; exactly 512 write cycles counted.
REQ-035 Drop start at cycle 100 -> IDLE next edge, s_wren=0 thereafter, done never asserts; re-raise start -> first read at address 0.
REQ-036 reset_n pulsed low mid-WR_I -> s_wren and done drop asynchronously; state IDLE; restart completes in 2048 cycles.
REQ-037 Done handshake: hold start 10 cycles past DONE -> done stays 1; lower start -> done=0 and IDLE next edge.
REQ-038 Macro on, identity S, key 0x000000: iterations 0 and 1 take 3 cycles with no writes; final S matches the macro-off run.

Source files
------------

// File: rtl/ksa_shuffle_fsm.sv
// ksa_shuffle_fsm
//
// RC4 key-schedule swap loop over a 256-byte S memory. For i = 0..255:
//   j = j + S[i] + key[i mod KEY_BYTES];  swap S[i], S[j]
// The S memory is external with a fixed 2-cycle read latency. Each
// iteration is read S[i], read S[j], write S[i], write S[j], 8 cycles total.
//
// Handshake: start is a level request held high for the whole operation.
// done rises when the 256th swap has been written. done stays high while
// start stays high. Dropping start in any active state returns the block to
// IDLE on the next edge, and no further write is issued.
//
// Optional feature macro: KSA_SHUFFLE_SKIP_EQUAL_EN
//   When defined, an iteration whose new j equals i skips the read of S[j]
//   and both writes. The swap would be a no-op, so the iteration takes
//   3 cycles instead of 8.
//
// Ports
//   CLOCK_50    in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   level request
//   secret_key  in   8*KEY_BYTES bits, key byte 0 in the most significant byte
//   s_q         in   S-memory read data (valid 2 edges after the address)
//   s_address   out  S-memory address
//   s_data      out  S-memory write data
//   s_wren      out  S-memory write enable
//   done        out  shuffle complete
//   debug_state out  current FSM state encoding, for observation
module ksa_shuffle_fsm #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             s_q,
    output logic [7:0]             s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    output logic                   done,
    output logic [3:0]             debug_state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD_I = 4'd1,
        WT_I = 4'd2,
        LT_I = 4'd3,
        RD_J = 4'd4,
        WT_J = 4'd5,
        LT_J = 4'd6,
        WR_I = 4'd7,
        WR_J = 4'd8,
        DONE = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] i, i_nxt;
    logic [7:0] j, j_nxt;
    logic [7:0] s_i, s_i_nxt;
    logic [7:0] s_j, s_j_nxt;

    int         key_sel;
    logic [7:0] key_byte;
    logic [7:0] j_new;

    // Key byte for the current i. Byte 0 is the most significant byte of
    // secret_key, so the shift counts down from the top.
    always_comb begin
        key_sel  = int'(i) % KEY_BYTES;
        key_byte = 8'(secret_key >> (8 * (KEY_BYTES - 1 - key_sel)));
        // 8-bit sum: wraps modulo 256 and drops the carry.
        j_new    = j + s_q + key_byte;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            s_i   <= 8'd0;
            s_j   <= 8'd0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            s_i   <= s_i_nxt;
            s_j   <= s_j_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        s_i_nxt   = s_i;
        s_j_nxt   = s_j;
        s_address = 8'd0;
        s_data    = 8'd0;
        s_wren    = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_I;
                    i_nxt     = 8'd0;
                    j_nxt     = 8'd0;
                end
            end
            RD_I: begin
                s_address = i;
                state_nxt = WT_I;
            end
            WT_I: begin
                s_address = i;
                state_nxt = LT_I;
            end
            LT_I: begin
                s_address = i;
                s_i_nxt   = s_q;
                j_nxt     = j_new;
                state_nxt = RD_J;
`ifdef KSA_SHUFFLE_SKIP_EQUAL_EN
                // Swapping S[i] with itself changes nothing, so move on.
                if (j_new == i) begin
                    if (i == 8'hFF) begin
                        state_nxt = DONE;
                    end else begin
                        i_nxt     = i + 8'd1;
                        state_nxt = RD_I;
                    end
                end
`endif
            end
            RD_J: begin
                s_address = j;
                state_nxt = WT_J;
            end
            WT_J: begin
                s_address = j;
                state_nxt = LT_J;
            end
            LT_J: begin
                s_address = j;
                s_j_nxt   = s_q;
                state_nxt = WR_I;
            end
            WR_I: begin
                s_address = i;
                s_data    = s_j;
                // Gated by start so that an abort in this cycle writes nothing.
                s_wren    = start;
                state_nxt = WR_J;
            end
            WR_J: begin
                s_address = j;
                s_data    = s_i;
                s_wren    = start;
                if (i == 8'hFF) begin
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i + 8'd1;
                    state_nxt = RD_I;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A dropped request ends any operation, including the DONE hold.
        if (!start) begin
            state_nxt = IDLE;
        end
    end

    assign debug_state = state;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Testbench for ksa_shuffle_fsm: 2-cycle-latency S memory model, an
// expected-write scoreboard, and directed scenarios covering identity and
// golden-key runs, abort, mid-write reset and the done handshake.
module tb_ksa_shuffle_fsm;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_RD_I = 4'd1;
    localparam logic [3:0] ST_WR_I = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd9;

`ifdef KSA_SHUFFLE_SKIP_EQUAL_EN
    localparam bit SKIP_EQ     = 1'b1;
    localparam int ITER2_EDGE  = 14;
`else
    localparam bit SKIP_EQ     = 1'b0;
    localparam int ITER2_EDGE  = 24;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        CLOCK_50;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  s_q;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic        done;
    logic [3:0]  debug_state;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    ksa_shuffle_fsm #(.KEY_BYTES(3)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .start       (start),
        .secret_key  (secret_key),
        .s_q         (s_q),
        .s_address   (s_address),
        .s_data      (s_data),
        .s_wren      (s_wren),
        .done        (done),
        .debug_state (debug_state)
    );

    // ---------------- S memory model (2-cycle read latency) ----------------
    logic [7:0] mem [256];
    logic [7:0] q1;
    logic       init_req;

    always @(posedge CLOCK_50) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        q1  <= mem[s_address];
        s_q <= q1;
    end

    // ---------------- scoreboard state ----------------
    int          total;
    int          bad;
    logic [15:0] exp_q[$];
    int          wr_edges[$];
    logic [7:0]  exp_final [256];
    int          exp_cycles;
    int          exp_writes;
    int          wr_cnt;
    bit          done_low_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every write the DUT presents is popped against the queue.
    always @(negedge CLOCK_50) begin
        if (s_wren) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {16'd0, s_address, s_data}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("write", {16'd0, s_address, s_data}, {16'd0, e});
            end
        end
        if (done_low_chk) chk("done_low", {31'd0, done}, 32'd0);
    end

    // ---------------- reference model ----------------
    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Software KSA from the current memory contents. The first skip_hand
    // writes are already in the queue from hand-computed vectors.
    task automatic model_run(input logic [23:0] key, input int skip_hand);
        logic [7:0] s [256];
        logic [7:0] jj, tmp, kb;
        int e;
        for (int k = 0; k < 256; k++) s[k] = mem[k];
        jj = 8'd0;
        e = 0;
        exp_writes = 0;
        wr_edges.delete();
        for (int ii = 0; ii < 256; ii++) begin
            kb = 8'(key >> (8 * (2 - (ii % 3))));
            jj = jj + s[ii] + kb;
            if (SKIP_EQ && jj == 8'(ii)) begin
                e += 3;
            end else begin
                if (exp_writes >= skip_hand) push_wr(8'(ii), s[jj]);
                exp_writes++;
                if (exp_writes > skip_hand) push_wr(jj, s[ii]);
                exp_writes++;
                wr_edges.push_back(e + 7);
                wr_edges.push_back(e + 8);
                tmp = s[ii];
                s[ii] = s[jj];
                s[jj] = tmp;
                e += 8;
            end
        end
        for (int k = 0; k < 256; k++) exp_final[k] = s[k];
        exp_cycles = e;
    endtask

    // ---------------- driver tasks ----------------
    task automatic init_identity();
        @(posedge CLOCK_50); #1;
        init_req = 1'b1;
        @(posedge CLOCK_50); #1;
        init_req = 1'b0;
    endtask

    task automatic run_full(input string tag, input int exp_edges, input bit iter2_chk);
        int cnt;
        int wr_base;
        int nbad;
        bit hit;
        @(posedge CLOCK_50); #1;
        wr_base = wr_cnt;
        start = 1'b1;
        cnt = 0;
        hit = 1'b0;
        while (cnt < 4000 && !hit) begin
            @(posedge CLOCK_50); #1;
            cnt++;
            if (cnt == 1) begin
                chk($sformatf("%s_first_addr", tag), {24'd0, s_address}, 32'd0);
                chk($sformatf("%s_first_state", tag), {28'd0, debug_state}, {28'd0, ST_RD_I});
            end
            if (iter2_chk && cnt == ITER2_EDGE + 1) begin
                chk($sformatf("%s_s2_after_iter2", tag), {24'd0, mem[2]}, 32'd3);
                chk($sformatf("%s_s3_after_iter2", tag), {24'd0, mem[3]}, 32'd2);
                chk($sformatf("%s_s0_after_iter2", tag), {24'd0, mem[0]}, 32'd0);
                chk($sformatf("%s_s1_after_iter2", tag), {24'd0, mem[1]}, 32'd1);
            end
            if (done) hit = 1'b1;
        end
        chk($sformatf("%s_done_edges", tag), cnt - 1, exp_edges);
        chk($sformatf("%s_queue_left", tag), exp_q.size(), 32'd0);
        chk($sformatf("%s_write_count", tag), wr_cnt - wr_base, exp_writes);
        chk($sformatf("%s_done_state", tag), {28'd0, debug_state}, {28'd0, ST_DONE});
        chk($sformatf("%s_done_addr_data", tag), {16'd0, s_address, s_data}, 32'd0);
        nbad = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== exp_final[k]) begin
                if (nbad == 0) $display("  first differing byte %0d: %0h vs %0h", k, mem[k], exp_final[k]);
                nbad++;
            end
        end
        chk($sformatf("%s_final_s_bad_bytes", tag), nbad, 32'd0);
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        chk("drop_done_low", {31'd0, done}, 32'd0);
        chk("drop_state_idle", {28'd0, debug_state}, {28'd0, ST_IDLE});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int committed;
        int target;
        total = 0;
        bad = 0;
        wr_cnt = 0;
        done_low_chk = 1'b0;
        init_req = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        secret_key = 24'h000000;

        // Reset state
        #1;
        chk("rst_state", {28'd0, debug_state}, {28'd0, ST_IDLE});
        chk("rst_outputs", {14'd0, s_address, s_data, s_wren, done}, 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        @(posedge CLOCK_50); #1;
        chk("post_rst_idle", {28'd0, debug_state}, {28'd0, ST_IDLE});

        // Test A: identity S, key 0, hand-computed opening writes.
        init_identity();
        secret_key = 24'h000000;
`ifdef KSA_SHUFFLE_SKIP_EQUAL_EN
        push_wr(8'd2, 8'd3);
        push_wr(8'd3, 8'd2);
        model_run(24'h000000, 2);
        run_full("keyzero", exp_cycles, 1'b1);
`else
        push_wr(8'd0, 8'd0);
        push_wr(8'd0, 8'd0);
        push_wr(8'd1, 8'd1);
        push_wr(8'd1, 8'd1);
        push_wr(8'd2, 8'd3);
        push_wr(8'd3, 8'd2);
        model_run(24'h000000, 6);
        run_full("keyzero", 2048, 1'b1);
`endif
        // Done handshake: hold start past DONE, then release.
        for (int c = 0; c < 10; c++) begin
            @(posedge CLOCK_50); #1;
            chk("done_hold", {31'd0, done}, 32'd1);
        end
        drop_start();

        // Test B: golden key 0x000102.
        init_identity();
        secret_key = 24'h000102;
        model_run(24'h000102, 0);
        run_full("golden", exp_cycles, 1'b0);
        chk("golden_writes_total", exp_writes, SKIP_EQ ? exp_writes : 512);
        drop_start();

        // Test C: abort at edge 100 after leaving IDLE, then restart.
        init_identity();
        model_run(24'h000102, 0);
        done_low_chk = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        repeat (101) @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        chk("abort_state_idle", {28'd0, debug_state}, {28'd0, ST_IDLE});
        chk("abort_wren_low", {31'd0, s_wren}, 32'd0);
        committed = 0;
        foreach (wr_edges[n]) if (wr_edges[n] <= 100) committed++;
        chk("abort_pending_writes", exp_q.size(), exp_writes - committed);
        exp_q.delete();
        repeat (20) @(posedge CLOCK_50);
        done_low_chk = 1'b0;
        model_run(24'h000102, 0);
        run_full("after_abort", exp_cycles, 1'b0);
        drop_start();

        // Test D: reset pulse while WR_I is active, then restart.
        init_identity();
        model_run(24'h000102, 0);
        target = wr_edges[6] - 1;
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        repeat (target + 1) @(posedge CLOCK_50);
        #2;
        chk("pre_rst_wren", {31'd0, s_wren}, 32'd1);
        chk("pre_rst_state", {28'd0, debug_state}, {28'd0, ST_WR_I});
        #1;
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        chk("async_rst_wren", {31'd0, s_wren}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_state", {28'd0, debug_state}, {28'd0, ST_IDLE});
        chk("async_rst_addr", {24'd0, s_address}, 32'd0);
        chk("rst_pending_writes", exp_q.size(), exp_writes - 6);
        exp_q.delete();
        @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        model_run(24'h000102, 0);
        run_full("after_reset", exp_cycles, 1'b0);
        drop_start();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
